// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
//   DEF_DATA_WIDTH : default data word width
//   DEF_ADDR_WIDTH : default storage address width (DEPTH = 2**ADDR_WIDTH)
//   ptr_width()    : pointer width, one wrap bit above the address bits
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage array for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from the array)
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with wrap-bit pointers, threshold flags,
// sticky overflow/underflow and selectable registered or FWFT read data.
//   clk, rst_n            : clock, asynchronous active-low reset
//   winc, wdata           : write request and data
//   rinc                  : read (pop) request
//   err_clr               : clears overflow/underflow
//   rdata                 : read data (registered)
//   wfull, rempty         : full / empty
//   walmost_full          : count >= AFULL_LEVEL
//   ralmost_empty         : count <= AEMPTY_LEVEL
//   count                 : occupancy 0..DEPTH
//   overflow, underflow   : sticky error flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned FWFT         = 0,
  parameter int unsigned AFULL_LEVEL  = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  wfull_q, wfull_d, rempty_q, rempty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc = winc && !wfull_q;
  assign rd_acc = rinc && !rempty_q;
  assign waddr  = wptr_q[ADDR_WIDTH-1:0];
  // FWFT looks up the head that will be current after this edge.
  assign raddr  = (FWFT != 0) ? rptr_d[ADDR_WIDTH-1:0] : rptr_q[ADDR_WIDTH-1:0];

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // Pointer, occupancy and flag next-state; flags are registered from the
  // next pointers so they track the pointers exactly.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
    count_d  = wptr_d - rptr_d;
    rempty_d = (wptr_d == rptr_d);
    wfull_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
               (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
    afull_d  = (count_d >= AFULL_L);
    aempty_d = (count_d <= AEMPTY_L);
    // Set has priority over a simultaneous clear.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (winc && wfull_q)  ovf_d = 1'b1;
    if (rinc && rempty_q) udf_d = 1'b1;
  end

  // Read data next-state
  always_comb begin
    rdata_d = rdata_q;
    if (FWFT != 0) begin
      // A word written this edge into the slot that becomes head is not yet
      // in the array, so forward it.
      rdata_d = (wr_acc && (waddr == raddr)) ? wdata : ram_rdata;
    end else if (rd_acc) begin
      rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata         = rdata_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed table-driven bench for param_sync_fifo: one registered-read
// instance (u_dut0) and one FWFT instance (u_dut1) on shared stimulus.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, afull0, aempty0, ovf0, udf0;
  logic       wfull1, rempty1, afull1, aempty1, ovf1, udf1;
  logic [4:0] count0, count1;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .err_clr(err_clr), .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(afull0), .ralmost_empty(aempty0), .count(count0),
    .overflow(ovf0), .underflow(udf0));

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .err_clr(err_clr), .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(afull1), .ralmost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  typedef struct {
    logic       winc, rinc, err_clr;
    logic [7:0] wdata;
    logic [4:0] count;
    logic       wfull, rempty, afull, aempty, ovf, udf;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Expected flags follow from occupancy for DEPTH=16, AFULL=14, AEMPTY=2.
  function automatic vec_t mk(input logic w, input logic r, input logic c,
                              input logic [7:0] wd, input int cnt,
                              input logic ovf, input logic udf,
                              input logic [7:0] rd);
    vec_t v;
    v.winc = w; v.rinc = r; v.err_clr = c; v.wdata = wd;
    v.count  = 5'(cnt);
    v.wfull  = (cnt == 16);
    v.rempty = (cnt == 0);
    v.afull  = (cnt >= 14);
    v.aempty = (cnt <= 2);
    v.ovf = ovf; v.udf = udf; v.rdata = rd;
    return v;
  endfunction

  task automatic check_dut0(input int idx, input vec_t v);
    chk("count",  idx, 32'(count0),  32'(v.count));
    chk("wfull",  idx, 32'(wfull0),  32'(v.wfull));
    chk("rempty", idx, 32'(rempty0), 32'(v.rempty));
    chk("afull",  idx, 32'(afull0),  32'(v.afull));
    chk("aempty", idx, 32'(aempty0), 32'(v.aempty));
    chk("ovf",    idx, 32'(ovf0),    32'(v.ovf));
    chk("udf",    idx, 32'(udf0),    32'(v.udf));
    chk("rdata",  idx, 32'(rdata0),  32'(v.rdata));
  endtask

  initial begin
    vec_t rst_v;
    rst_v = mk(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00);

    // Fill 16, overflow attempt, drain 16, underflow, clear.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'(i), i + 1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'hAA, 16, 1'b1, 1'b0, 8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 15 - i, 1'b1, 1'b0, 8'(i)));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 8'h0F));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h0F));
    // Prime 8 entries, then 40 simultaneous read+write cycles (pointers wrap).
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'(16 + i), i + 1, 1'b0, 1'b0, 8'h0F));
    for (int k = 0; k < 40; k++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'(24 + k), 8, 1'b0, 1'b0, 8'(16 + k)));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h40, 9, 1'b0, 1'b0, 8'h37));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_dut0(-1, rst_v);
    chk("fwft_rst_rempty", -1, 32'(rempty1), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      winc = vecs[i].winc; rinc = vecs[i].rinc;
      err_clr = vecs[i].err_clr; wdata = vecs[i].wdata;
      @(posedge clk);
      #1;
      check_dut0(i, vecs[i]);
    end

    // Reset asserted mid-burst at count=9: outputs clear before any edge.
    winc = 1'b1; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h41;
    #2 rst_n = 1'b0;
    #1;
    check_dut0(100, rst_v);
    chk("fwft_midrst_count", 100, 32'(count1), 32'd0);
    winc = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First write after release is accepted; FWFT shows it without a read.
    winc = 1'b1; wdata = 8'h5A;
    @(posedge clk); #1; winc = 1'b0;
    chk("post_rst_count",   101, 32'(count0),  32'd1);
    chk("fwft_rempty",      101, 32'(rempty1), 32'd0);
    chk("fwft_rdata_first", 101, 32'(rdata1),  32'h5A);
    chk("reg_rdata_hold",   101, 32'(rdata0),  32'h00);

    winc = 1'b1; wdata = 8'h5B;
    @(posedge clk); #1; winc = 1'b0;
    chk("fwft_rdata_keep",  102, 32'(rdata1),  32'h5A);
    chk("fwft_count",       102, 32'(count1),  32'd2);

    rinc = 1'b1;
    @(posedge clk); #1;
    chk("fwft_rdata_adv",   103, 32'(rdata1),  32'h5B);
    chk("reg_rdata_first",  103, 32'(rdata0),  32'h5A);

    @(posedge clk); #1; rinc = 1'b0;
    chk("fwft_empty",       104, 32'(rempty1), 32'd1);
    chk("reg_rdata_second", 104, 32'(rdata0),  32'h5B);
    chk("reg_empty",        104, 32'(rempty0), 32'd1);
    chk("fwft_count0",      104, 32'(count1),  32'd0);
    chk("fwft_wfull",       104, 32'(wfull1),  32'd0);
    chk("fwft_afull",       104, 32'(afull1),  32'd0);
    chk("fwft_aempty",      104, 32'(aempty1), 32'd1);
    chk("fwft_ovf",         104, 32'(ovf1),    32'd0);
    chk("fwft_udf",         104, 32'(udf1),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
